// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction is 10's complement: a + (9-b) + 1 per digit chain.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          sub_r;
  logic          carry;
  logic [IW-1:0] idx;

  logic [3:0] da;
  logic [3:0] db;
  logic [3:0] dbp;
  logic [3:0] dig;
  logic [4:0] s;
  logic       c_nxt;
  logic       bad;

  // Single-digit slice: only the low nibble of each shift register is used.
  always_comb begin
    da    = a_sh[3:0];
    db    = b_sh[3:0];
    dbp   = sub_r ? (4'd9 - db) : db;
    s     = {1'b0, da} + {1'b0, dbp} + {4'd0, carry};
    c_nxt = (s > 5'd9);
    dig   = c_nxt ? (s[3:0] + 4'd6) : s[3:0];
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            carry <= sub | cin;
            idx   <= '0;
            err   <= bad;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[4*int'(idx) +: 4] <= dig;
          carry <= c_nxt;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            cout  <= c_nxt;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4).
// Vector table plus scoreboard queue, with handshake/reset corner sequences.
module tb_bcd_serial_addsub;

  localparam int D = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sub;
  logic          cin;
  logic [15:0]   a;
  logic [15:0]   b;
  logic [15:0]   sum;
  logic          cout;
  logic          err;
  logic          busy;
  logic          done;

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic        chk;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Waits for done; returns cycles since acceptance edge, or 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    int   lat;
    sub   = v.sub;
    cin   = v.cin;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    e.sum  = v.sum;
    e.cout = v.cout;
    e.err  = v.err;
    e.chk  = v.chk;
    sb.push_back(e);
    step();
    start = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " err_early"}, 32'(err), 32'(v.err));
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'(D));
    if (lat != 0 && sb.size() > 0) begin
      g = sb.pop_front();
      if (g.chk) check({tag, " sum"}, 32'(sum), 32'(g.sum));
      if (g.chk) check({tag, " cout"}, 32'(cout), 32'(g.cout));
      check({tag, " err"}, 32'(err), 32'(g.err));
    end else begin
      sb.delete();
    end
    step();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dn;
    int first;
    int last;
    int lat;
    n_chk  = 0;
    n_pass = 0;

    vecs[0]  = '{1'b0, 1'b0, 16'h1234, 16'h8766, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 16'h9999, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 16'h0458, 16'h0273, 16'h0731, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 16'h9999, 16'h9999, 16'h9999, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'h9999, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    rst = 1'b0;
    check("rst sum", 32'(sum), 32'd0);
    check("rst flags", {28'd0, cout, err, busy, done}, 32'd0);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // start held high: one accept per D+2 cycles, operands stay fixed
    sub   = 1'b0;
    cin   = 1'b0;
    a     = 16'h0001;
    b     = 16'h0002;
    start = 1'b1;
    dn    = 0;
    first = 0;
    last  = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 10) start = 1'b0;
      if (done === 1'b1) begin
        dn++;
        if (first == 0) first = c;
        last = c;
        check("held sum", 32'(sum), 32'h0003);
      end
    end
    check("held done count", 32'(dn), 32'd2);
    check("held spacing", 32'(last - first), 32'(D + 2));

    // start pulses while busy are ignored; latched operands are used
    a     = 16'h0100;
    b     = 16'h0200;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = 16'h0999;
    b     = 16'h0999;
    sub   = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
    check("busy_pulse latency", 32'(lat), 32'(D - 2));
    check("busy_pulse sum", 32'(sum), 32'h0300);
    check("busy_pulse cout", 32'(cout), 32'd0);
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done === 1'b1) dn++;
    end
    check("busy_pulse extra done", 32'(dn), 32'd0);

    // reset two cycles into RUN aborts with no done
    sub   = 1'b0;
    a     = 16'h1111;
    b     = 16'h2222;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort sum", 32'(sum), 32'd0);
    check("abort flags", {28'd0, cout, err, busy, done}, 32'd0);
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done === 1'b1) dn++;
    end
    check("abort no done", 32'(dn), 32'd0);
    run_op('{1'b0, 1'b0, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 1'b1},
           "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised, digit-serial BCD adder/subtractor for multi-digit packed-BCD operands. It is the sequential successor of the single-digit combinational BCD adder. It processes one decimal digit per clock, least-significant first, and adds 10's-complement subtraction, a start/done handshake and invalid-digit detection. It sits between operand registers and BCD display/accumulator logic in the arithmetic datapath.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS bits.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  mode, sampled with start: 0 = a+b+cin, 1 = a−b.
- cin  in  1  carry-in for add mode, sampled with start; ignored when sub=1.
- a  in  4*DIGITS  packed BCD operand; digit i is a[4i+3:4i].
- b  in  4*DIGITS  packed BCD operand, same packing.
- sum  out  4*DIGITS  packed BCD result.
- cout  out  1  add: decimal carry out; sub: 1 = no borrow (a≥b).
- err  out  1  1 if any digit of a or b was >9 when start was sampled.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; the result is final in that cycle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: latch a and b into shift registers. Latch sub and the digit index (0). Set the carry register to (sub ? 1 : cin). Compute and latch err. Clear sum. Go to RUN.
- IDLE with start=0: outputs hold their values.
- RUN, one digit per edge:
  - Take da, the current digit of a.
  - Take db' = sub ? (9 − db) : db, where db is the current digit of b.
  - Form the 5-bit binary sum s = da + db' + c.
  - If s > 9: digit = (s + 6) mod 16 and carry becomes 1. Otherwise digit = s and carry becomes 0.
  - Write the digit into sum position idx, then increment idx.
- After the digit with idx = DIGITS−1: cout takes the final carry and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Subtraction with a<b yields 10^DIGITS − (b − a) with cout=0; no sign-magnitude conversion.
- Invalid digits (>9): no abort. Arithmetic runs on the raw nibbles and the result is unspecified, but err=1 is mandatory.
- start in RUN or DONE is ignored. There is no queueing and no abort.
- sum, cout and err hold from DONE until the next accepted start clears sum, cout and err.
- During RUN, sum shows partially written digits; consumers use done only.

## Timing
- Reset (synchronous, rst=1 at an edge): state=IDLE, sum=0, cout=0, err=0, busy=0, done=0, idx=0, carry=0. rst has priority over start.
- rst during RUN aborts the operation with no done pulse.
- Let edge k be the edge where start is accepted:
  - busy=1 from after edge k.
  - Digits are processed on edges k+1 … k+DIGITS.
  - done=1 and the final sum/cout are visible after edge k+DIGITS, for one cycle.
  - IDLE after edge k+DIGITS+1.
- Latency from start to done is DIGITS+1 cycles. Back-to-back throughput is one operation per DIGITS+2 cycles: start may be accepted in the cycle after done.
- err is valid from the cycle after edge k and stays stable until the next accepted start.
- The per-digit combinational path is one 4-bit add, a >9 compare and a +6 correct. There is no path whose depth grows with DIGITS.

## Test plan
- DIGITS=4, add, a=0x1234, b=0x8766, cin=0 → after 5 cycles done=1, sum=0x0000, cout=1, err=0.
- Add, a=0x9999, b=0x0000, cin=1 → sum=0x0000, cout=1. Then a=0x0458, b=0x0273, cin=0 → sum=0x0731, cout=0.
- Sub, a=0x5000, b=0x1234 → sum=0x3766, cout=1. Sub, a=0x1234, b=0x5000 → sum=0x6234, cout=0.
- Invalid input a=0x00A0, b=0x0001 → err=1 in the cycle after start, still set at done. A following valid operation clears err to 0.
- start held high for 10 cycles → exactly one done per DIGITS+2 cycles. start pulses during busy produce no extra done, and the operands latched at acceptance are used.
- rst asserted 2 cycles into RUN → next cycle all outputs are 0, no done pulse. A new start then completes normally with a correct result.
